// File: rtl/alu_staged_if.sv
// alu_staged_if: operand/command/result bundle for alu_staged.
//   master : drives ce, opa, opb, cin, mode, cmd, inp_valid; receives results
//   slave  : the ALU side; drives res, cout, oflow, g, l, e, err, res_valid, busy
interface alu_staged_if #(
  parameter int unsigned W = 8
);
  logic         ce;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic         mode;
  logic [3:0]   cmd;
  logic [1:0]   inp_valid;

  logic [2*W-1:0] res;
  logic           cout;
  logic           oflow;
  logic           g;
  logic           l;
  logic           e;
  logic           err;
  logic           res_valid;
  logic           busy;

  modport master (
    output ce, opa, opb, cin, mode, cmd, inp_valid,
    input  res, cout, oflow, g, l, e, err, res_valid, busy
  );

  modport slave (
    input  ce, opa, opb, cin, mode, cmd, inp_valid,
    output res, cout, oflow, g, l, e, err, res_valid, busy
  );
endinterface

// File: rtl/alu_staged.sv
// alu_staged: ALU core with operand staging.
// Operands may arrive together (inp_valid=11) or on separate cycles; a lone
// operand of a two-operand command is held for up to TIMEOUT enabled cycles,
// after which an error result is produced. Results are registered and marked
// by a one-enabled-cycle res_valid strobe.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (priority over ce)
//   bus  - alu_staged_if.slave: ce, opa, opb, cin, mode, cmd, inp_valid in;
//          res (2W, zero-extended), cout, oflow, g, l, e, err, res_valid, busy out
//
// Build option: define ALU_MUL_EN to execute arithmetic cmd 9 (MUL_INC) and
// cmd 10 (MUL_SHL) through a two-stage multiply pipeline (MUL2 state, busy).
// Without it those codes are undefined commands and busy is tied low.
module alu_staged #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  alu_staged_if.slave bus
);

  localparam int unsigned AW        = $clog2(W);
  localparam int unsigned CW        = $clog2(TIMEOUT + 1);
  localparam int unsigned ROT_STEPS = 1 << AW;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           l;
    logic           e;
    logic           err;
  } result_t;

  typedef struct packed {
    logic need_a;
    logic need_b;
  } kind_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

  // Single-operand commands only wait on their own operand; everything else,
  // including undefined codes, needs both.
  function automatic kind_t classify(input logic m, input logic [3:0] c);
    kind_t k;
    k.need_a = 1'b1;
    k.need_b = 1'b1;
    if (m) begin
      case (c)
        4'd4, 4'd5: k.need_b = 1'b0;
        4'd6, 4'd7: k.need_a = 1'b0;
        default: ;
      endcase
    end else begin
      case (c)
        4'd6, 4'd8, 4'd9:   k.need_b = 1'b0;
        4'd7, 4'd10, 4'd11: k.need_a = 1'b0;
        default: ;
      endcase
    end
    return k;
  endfunction

  // Rotation by amounts >= W (non power-of-two W) simply wraps further.
  function automatic logic [W-1:0] rotate(input logic [W-1:0] a,
                                          input logic [AW-1:0] amt,
                                          input logic left);
    logic [W-1:0] r;
    r = a;
    for (int unsigned i = 0; i < ROT_STEPS; i++) begin
      if (i < 32'(amt)) begin
        r = left ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
      end
    end
    return r;
  endfunction

  function automatic result_t evaluate(input logic m, input logic [3:0] c,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic ci);
    result_t      r;
    logic [W:0]   wide;
    logic [W-1:0] narrow;
    r      = '0;
    wide   = '0;
    narrow = '0;
    if (m) begin
      case (c)
        4'd0: begin
          wide   = {1'b0, a} + {1'b0, b};
          r.res  = (2*W)'(wide);
          r.cout = wide[W];
        end
        4'd1: begin
          narrow  = a - b;
          r.res   = (2*W)'(narrow);
          r.oflow = (a < b);
        end
        4'd2: begin
          wide   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
          r.res  = (2*W)'(wide);
          r.cout = wide[W];
        end
        4'd3: begin
          narrow  = a - b - W'(ci);
          r.res   = (2*W)'(narrow);
          r.oflow = ({1'b0, a} < ({1'b0, b} + (W+1)'(ci)));
        end
        4'd4: begin
          wide   = {1'b0, a} + (W+1)'(1);
          r.res  = (2*W)'(wide);
          r.cout = wide[W];
        end
        4'd5: begin
          narrow  = a - W'(1);
          r.res   = (2*W)'(narrow);
          r.oflow = (a == '0);
        end
        4'd6: begin
          wide   = {1'b0, b} + (W+1)'(1);
          r.res  = (2*W)'(wide);
          r.cout = wide[W];
        end
        4'd7: begin
          narrow  = b - W'(1);
          r.res   = (2*W)'(narrow);
          r.oflow = (b == '0);
        end
        4'd8: begin
          r.g = (a > b);
          r.l = (a < b);
          r.e = (a == b);
        end
        default: r.err = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:  narrow = a & b;
        4'd1:  narrow = ~(a & b);
        4'd2:  narrow = a | b;
        4'd3:  narrow = ~(a | b);
        4'd4:  narrow = a ^ b;
        4'd5:  narrow = ~(a ^ b);
        4'd6:  narrow = ~a;
        4'd7:  narrow = ~b;
        4'd8:  narrow = a >> 1;
        4'd9:  narrow = a << 1;
        4'd10: narrow = b >> 1;
        4'd11: narrow = b << 1;
        4'd12, 4'd13: begin
          if ((b >> AW) != '0) r.err = 1'b1;
          else narrow = rotate(a, b[AW-1:0], (c == 4'd12));
        end
        default: r.err = 1'b1;
      endcase
      r.res = (2*W)'(narrow);
    end
    return r;
  endfunction

  state_t       state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic [W-1:0] hold_q;
  logic         hold_is_a, hold_is_a_next;
  logic         hold_load, latch_cmd;
  logic         l_mode, l_cin;
  logic [3:0]   l_cmd;

  logic         iss_mode, iss_cin;
  logic [3:0]   iss_cmd;
  logic [W-1:0] iss_a, iss_b;
  kind_t        kind;
  logic         issue, timeout, missing, resent;
  logic         mul_issue, mul_done;
  result_t      result, out_next, out_q;
  logic         emit, res_valid_q;

`ifdef ALU_MUL_EN
  logic [W:0]     mul_x, mul_y;
  logic [2*W-1:0] mul_p;
  assign mul_p = (2*W)'(mul_x) * (2*W)'(mul_y);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (bus.ce) begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    issue          = 1'b0;
    timeout        = 1'b0;
    missing        = 1'b0;
    resent         = 1'b0;
    hold_load      = 1'b0;
    latch_cmd      = 1'b0;
    hold_is_a_next = hold_is_a;
    mul_issue      = 1'b0;
    mul_done       = 1'b0;
    // While waiting, the command captured with the first operand is used.
    iss_mode = (state == S_WAIT) ? l_mode : bus.mode;
    iss_cmd  = (state == S_WAIT) ? l_cmd  : bus.cmd;
    iss_cin  = (state == S_WAIT) ? l_cin  : bus.cin;
    iss_a    = bus.opa;
    iss_b    = bus.opb;
    kind     = classify(iss_mode, iss_cmd);

    case (state)
      S_IDLE: begin
        if (kind.need_a && kind.need_b) begin
          case (bus.inp_valid)
            2'b11: issue = 1'b1;
            2'b01, 2'b10: begin
              hold_load      = 1'b1;
              latch_cmd      = 1'b1;
              hold_is_a_next = bus.inp_valid[0];
              cnt_next       = CW'(1);
              state_next     = S_WAIT;
            end
            default: ;
          endcase
        end else if (kind.need_a) begin
          issue = bus.inp_valid[0];
        end else begin
          issue = bus.inp_valid[1];
        end
      end
      S_WAIT: begin
        // A resent held operand in the completing cycle takes the fresh value.
        if (hold_is_a) begin
          if (!bus.inp_valid[0]) iss_a = hold_q;
          missing = bus.inp_valid[1];
          resent  = bus.inp_valid[0];
        end else begin
          if (!bus.inp_valid[1]) iss_b = hold_q;
          missing = bus.inp_valid[0];
          resent  = bus.inp_valid[1];
        end
        if (missing) begin
          issue      = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (cnt == CW'(TIMEOUT)) begin
          timeout    = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next  = cnt + CW'(1);
          hold_load = resent;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL2: begin
        mul_done   = 1'b1;
        state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase

`ifdef ALU_MUL_EN
    mul_issue = issue && iss_mode && ((iss_cmd == 4'd9) || (iss_cmd == 4'd10));
    if (mul_issue) state_next = S_MUL2;
`endif

    result   = evaluate(iss_mode, iss_cmd, iss_a, iss_b, iss_cin);
    emit     = 1'b0;
    out_next = result;
    if (timeout) begin
      emit         = 1'b1;
      out_next     = '0;
      out_next.err = 1'b1;
    end else if (issue && !mul_issue) begin
      emit = 1'b1;
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      emit         = 1'b1;
      out_next     = '0;
      out_next.res = mul_p;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_is_a   <= 1'b0;
      l_mode      <= 1'b0;
      l_cmd       <= '0;
      l_cin       <= 1'b0;
      out_q       <= '0;
      res_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      mul_x       <= '0;
      mul_y       <= '0;
`endif
    end else if (bus.ce) begin
      if (hold_load) begin
        hold_q    <= hold_is_a_next ? bus.opa : bus.opb;
        hold_is_a <= hold_is_a_next;
      end
      if (latch_cmd) begin
        l_mode <= bus.mode;
        l_cmd  <= bus.cmd;
        l_cin  <= bus.cin;
      end
`ifdef ALU_MUL_EN
      // Stage 1 forms the two factors; stage 2 (MUL2) multiplies them.
      if (mul_issue) begin
        mul_x <= (iss_cmd == 4'd9) ? ({1'b0, iss_a} + (W+1)'(1)) : {iss_a, 1'b0};
        mul_y <= (iss_cmd == 4'd9) ? ({1'b0, iss_b} + (W+1)'(1)) : {1'b0, iss_b};
      end
`endif
      if (emit) out_q <= out_next;
      res_valid_q <= emit;
    end
  end

  assign bus.res       = out_q.res;
  assign bus.cout      = out_q.cout;
  assign bus.oflow     = out_q.oflow;
  assign bus.g         = out_q.g;
  assign bus.l         = out_q.l;
  assign bus.e         = out_q.e;
  assign bus.err       = out_q.err;
  assign bus.res_valid = res_valid_q;
`ifdef ALU_MUL_EN
  assign bus.busy      = (state == S_MUL2);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_staged.sv
module tb_alu_staged;
  localparam int W  = 8;
  localparam int TO = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_staged_if #(.W(W)) bus ();

  alu_staged #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       res;
    bit [5:0] flags;   // {cout, oflow, g, l, e, err}
    int       at;      // enabled-edge index at which the result must appear
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   en_edges = 0;
  bit   ce_edge = 1'b0;

  // abstract model state: a pending lone operand and its age in enabled cycles
  bit pend = 1'b0, pend_is_a = 1'b0, pend_mode = 1'b0, pend_cin = 1'b0;
  int pend_val = 0, pend_cmd = 0, age = 0;
  bit mul_next = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_op(bit m, int c, int a, int b, bit ci);
    exp_t x;
    int r = 0;
    bit co = 0, ov = 0, gg = 0, ll = 0, ee = 0, er = 0;
    if (m) begin
      case (c)
        0: begin r = a + b; co = (r > 255); end
        1: begin r = (a - b + 256) % 256; ov = (a < b); end
        2: begin r = a + b + int'(ci); co = (r > 255); end
        3: begin r = (a - b - int'(ci) + 512) % 256; ov = (a < b + int'(ci)); end
        4: begin r = a + 1; co = (r > 255); end
        5: begin r = (a + 255) % 256; ov = (a == 0); end
        6: begin r = b + 1; co = (r > 255); end
        7: begin r = (b + 255) % 256; ov = (b == 0); end
        8: begin gg = (a > b); ll = (a < b); ee = (a == b); end
        9: if (MUL_EN) r = ((a + 1) * (b + 1)) % 65536; else er = 1;
        10: if (MUL_EN) r = (2 * a * b) % 65536; else er = 1;
        default: er = 1;
      endcase
    end else begin
      case (c)
        0: r = a & b;
        1: r = 255 - (a & b);
        2: r = a | b;
        3: r = 255 - (a | b);
        4: r = a ^ b;
        5: r = 255 - (a ^ b);
        6: r = 255 - a;
        7: r = 255 - b;
        8: r = a / 2;
        9: r = (2 * a) % 256;
        10: r = b / 2;
        11: r = (2 * b) % 256;
        12: if (b > 7) er = 1; else r = ((a << b) % 256) + (a >> (8 - b));
        13: if (b > 7) er = 1; else r = (a >> b) + ((a << (8 - b)) % 256);
        default: er = 1;
      endcase
    end
    x.res = r;
    x.flags = {co, ov, gg, ll, ee, er};
    x.at = 0;
    return x;
  endfunction

  // [1] = needs opa, [0] = needs opb
  function automatic bit [1:0] needs(bit m, int c);
    if (m && (c == 4 || c == 5)) return 2'b10;
    if (m && (c == 6 || c == 7)) return 2'b01;
    if (!m && (c == 6 || c == 8 || c == 9)) return 2'b10;
    if (!m && (c == 7 || c == 10 || c == 11)) return 2'b01;
    return 2'b11;
  endfunction

  task automatic model_issue(bit m, int c, int a, int b, bit ci, int k);
    exp_t x = ref_op(m, c, a, b, ci);
    bit mulop = MUL_EN && m && (c == 9 || c == 10);
    x.at = mulop ? k + 1 : k;
    if (mulop) mul_next = 1'b1;
    sb.push_back(x);
  endtask

  task automatic model_edge(bit [1:0] iv, bit m, int c, int a, int b, bit ci, int k);
    bit [1:0] nd;
    bit miss;
    exp_t x;
    if (mul_next) begin
      mul_next = 1'b0;
    end else if (pend) begin
      miss = pend_is_a ? iv[1] : iv[0];
      if (miss) begin
        model_issue(pend_mode, pend_cmd,
                    pend_is_a ? (iv[0] ? a : pend_val) : a,
                    pend_is_a ? b : (iv[1] ? b : pend_val),
                    pend_cin, k);
        pend = 1'b0;
      end else if (age == TO) begin
        x.res = 0; x.flags = 6'b000001; x.at = k;
        sb.push_back(x);
        pend = 1'b0;
      end else begin
        age++;
        if (pend_is_a && iv[0]) pend_val = a;
        if (!pend_is_a && iv[1]) pend_val = b;
      end
    end else begin
      nd = needs(m, c);
      if (nd == 2'b11) begin
        if (iv == 2'b11) model_issue(m, c, a, b, ci, k);
        else if (iv != 2'b00) begin
          pend = 1'b1; pend_is_a = iv[0]; pend_val = iv[0] ? a : b;
          pend_mode = m; pend_cmd = c; pend_cin = ci; age = 1;
        end
      end else if ((nd == 2'b10 && iv[0]) || (nd == 2'b01 && iv[1])) begin
        model_issue(m, c, a, b, ci, k);
      end
    end
  endtask

  task automatic step(bit c_e, bit r, bit [1:0] iv, bit m, int c, int a, int b, bit ci);
    bus.ce = c_e;
    rst = r;
    bus.inp_valid = iv;
    bus.mode = m;
    bus.cmd = c[3:0];
    bus.opa = a[W-1:0];
    bus.opb = b[W-1:0];
    bus.cin = ci;
    if (r) begin
      pend = 1'b0;
      mul_next = 1'b0;
    end else if (c_e) begin
      model_edge(iv, m, c, a, b, ci, en_edges + 1);
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    ce_edge <= bus.ce;
    if (bus.ce) en_edges <= en_edges + 1;
  end

  // monitor: every fresh res_valid strobe consumes one expected result
  always @(negedge clk) begin
    exp_t x;
    if (ce_edge && bus.res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_result: res_valid with res %0h, required no result", bus.res);
      end else begin
        x = sb.pop_front();
        check("res", 64'(bus.res), 64'(x.res));
        check("flags", 64'({bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err}), 64'(x.flags));
        check("latency", 64'(en_edges), 64'(x.at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    step(1, 1, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, 2'b00, 0, 0, 0, 0, 0);
    check("reset_res", 64'(bus.res), 64'd0);
    check("reset_flags", 64'({bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err}), 64'd0);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);

    // full-pair ADD with carry out
    step(1, 0, 2'b11, 1, 0, 200, 100, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    // split ADD, second cycle carries a cmd that must be ignored
    step(1, 0, 2'b01, 1, 0, 5, 0, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    step(1, 0, 2'b10, 1, 4, 0, 7, 0);
    // timeout with ce held high
    step(1, 0, 2'b01, 1, 0, 9, 0, 0);
    for (int i = 0; i < TO; i++) step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    // timeout stretched by five disabled cycles
    step(1, 0, 2'b01, 1, 0, 9, 0, 0);
    for (int i = 0; i < TO + 5; i++) step(i % 4 != 1 || i > 18, 0, 2'b00, 1, 0, 0, 0, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    // rotates, in-range and out-of-range amount
    step(1, 0, 2'b11, 0, 12, 8'h81, 1, 0);
    step(1, 0, 2'b11, 0, 12, 8'h81, 8'h11, 0);
    step(1, 0, 2'b11, 0, 13, 8'h81, 3, 0);
    // compare, subtract borrow, decrement from zero
    step(1, 0, 2'b11, 1, 8, 7, 7, 0);
    step(1, 0, 2'b11, 1, 3, 4, 4, 1);
    step(1, 0, 2'b01, 1, 5, 0, 0, 0);
    // MUL_INC 3,4
    step(1, 0, 2'b11, 1, 9, 3, 4, 0);
    check("busy_mul_stage2", 64'(bus.busy), 64'(MUL_EN));
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    check("busy_after_mul", 64'(bus.busy), 64'd0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    // reset while waiting for an operand
    step(1, 0, 2'b01, 1, 0, 9, 0, 0);
    step(1, 1, 2'b00, 1, 0, 0, 0, 0);
    check("rst_wait_res", 64'(bus.res), 64'd0);
    check("rst_wait_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_wait_flags", 64'({bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err}), 64'd0);
    step(1, 0, 2'b11, 1, 0, 1, 1, 0);
    step(1, 0, 2'b00, 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int a = int'($urandom_range(0, 255));
      int b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
      step($urandom_range(0, 9) != 0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < TO + 4; i++) step(1, 0, 2'b00, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
